// File: rtl/and_vec_sequencer_pkg.sv
// Shared types and constants for the exhaustive AND-gate vector sequencer.
package vec_seq_pkg;

    localparam int unsigned DEF_WIDTH = 2;
    localparam int unsigned DEF_DWELL = 10;
    localparam int unsigned DEF_ERRW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of (a,b) operand pairs for a given operand width.
    function automatic int unsigned nvec(input int unsigned width);
        return 32'd1 << (2 * width);
    endfunction

endpackage

// File: rtl/and_vec_sequencer_if.sv
// Control, operand and status bundle between the sequencer and its host/gate.
interface and_vec_sequencer_if import vec_seq_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ERRW  = DEF_ERRW
);
    logic                 start;
    logic                 pause;
    logic                 abort;
    logic [WIDTH-1:0]     y_in;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 vec_valid;
    logic [2*WIDTH-1:0]   vec_idx;
    logic                 busy;
    logic                 done;
    logic [ERRW-1:0]      err_cnt;

    modport master (
        output start, pause, abort, y_in,
        input  a, b, vec_valid, vec_idx, busy, done, err_cnt
    );

    modport slave (
        input  start, pause, abort, y_in,
        output a, b, vec_valid, vec_idx, busy, done, err_cnt
    );
endinterface

// File: rtl/and_vec_sequencer_dwell_timer.sv
// Per-vector hold counter; last_c flags the final hold cycle of the current vector.
module dwell_timer #(
    parameter int unsigned DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic last_c
);
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign last_c = (cnt == LAST);

    // Wraps to zero after the last cycle so the next vector starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/and_vec_sequencer.sv
// Steps every (a,b) pair through the gate under test, holds each for DWELL cycles
// and counts cycles where y_in differs from a&b on the last hold cycle.
module and_vec_sequencer import vec_seq_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DWELL = DEF_DWELL,
    parameter int unsigned ERRW  = DEF_ERRW
) (
    input logic               clk,
    input logic               rst_n,
    and_vec_sequencer_if.slave bus
);
    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned NV = nvec(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NV - 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [ERRW-1:0]   err_q, err_d;
    logic              run_q, done_q;
    logic              tick_en_c;
    logic              last_c;
    logic              mismatch_c;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ST_RUN),
        .en     (tick_en_c),
        .last_c (last_c)
    );

    assign mismatch_c = (bus.y_in != (bus.a & bus.b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority inside each state: abort, then pause, then start/sequencing.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        tick_en_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (!bus.pause && bus.start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    err_d   = '0;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (!bus.pause) begin
                    tick_en_c = 1'b1;
                    if (last_c) begin
                        if (mismatch_c && (err_q != '1)) begin
                            err_d = err_q + ERRW'(1);
                        end
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + IW'(1);
                        end else begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            err_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            err_q  <= err_d;
            run_q  <= (state_d == ST_RUN);
            done_q <= (state_d == ST_DONE);
        end
    end

    assign bus.vec_idx   = idx_q;
    assign bus.a         = idx_q[IW-1:WIDTH];
    assign bus.b         = idx_q[WIDTH-1:0];
    assign bus.vec_valid = run_q;
    assign bus.busy      = run_q;
    assign bus.done      = done_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_and_vec_sequencer.sv
// Directed and randomized runs of two sequencer instances (DWELL=10/ERRW=8, DWELL=1/ERRW=2).
module tb_and_vec_sequencer;
    import vec_seq_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned NV = nvec(W);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    and_vec_sequencer_if #(.WIDTH(W), .ERRW(8)) bus0 ();
    and_vec_sequencer_if #(.WIDTH(W), .ERRW(2)) bus1 ();

    and_vec_sequencer #(.WIDTH(W), .DWELL(10), .ERRW(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    and_vec_sequencer #(.WIDTH(W), .DWELL(1), .ERRW(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int           sel;
    int           mode;      // 0: true gate, 1: y stuck at 0, 2: inverted on vectors flagged in inj
    logic [NV-1:0] inj;
    logic         start_r, pause_r, abort_r;
    int           ncmp, nfail;

    assign bus0.start = start_r && (sel == 0);
    assign bus0.pause = pause_r && (sel == 0);
    assign bus0.abort = abort_r && (sel == 0);
    assign bus1.start = start_r && (sel == 1);
    assign bus1.pause = pause_r && (sel == 1);
    assign bus1.abort = abort_r && (sel == 1);

    assign bus0.y_in = (mode == 1) ? '0 :
                       ((mode == 2 && inj[bus0.vec_idx]) ? ~(bus0.a & bus0.b) : (bus0.a & bus0.b));
    assign bus1.y_in = (mode == 1) ? '0 :
                       ((mode == 2 && inj[bus1.vec_idx]) ? ~(bus1.a & bus1.b) : (bus1.a & bus1.b));

    logic [2*W-1:0] o_idx;
    logic [W-1:0]   o_a, o_b;
    logic           o_valid, o_busy, o_done;
    logic [7:0]     o_err;
    assign o_idx   = (sel == 1) ? bus1.vec_idx   : bus0.vec_idx;
    assign o_a     = (sel == 1) ? bus1.a         : bus0.a;
    assign o_b     = (sel == 1) ? bus1.b         : bus0.b;
    assign o_valid = (sel == 1) ? bus1.vec_valid : bus0.vec_valid;
    assign o_busy  = (sel == 1) ? bus1.busy      : bus0.busy;
    assign o_done  = (sel == 1) ? bus1.done      : bus0.done;
    assign o_err   = (sel == 1) ? {6'b0, bus1.err_cnt} : bus0.err_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: does the injected y differ from the true AND for vector v?
    function automatic bit vec_bad(input int v);
        int av, bv;
        av = v >> W;
        bv = v % (1 << W);
        case (mode)
            1:       return (av & bv) != 0;
            2:       return inj[v];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_err(input int ndone, input int errmax);
        int e = 0;
        for (int v = 0; v < ndone; v++) if (vec_bad(v)) e++;
        return (e > errmax) ? errmax : e;
    endfunction

    task automatic chk_idle(input string tag, input int e);
        chk({tag, "_busy"},  32'(o_busy),  0);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_done"},  32'(o_done),  0);
        chk({tag, "_idx"},   32'(o_idx),   0);
        chk({tag, "_a"},     32'(o_a),     0);
        chk({tag, "_b"},     32'(o_b),     0);
        chk({tag, "_err"},   32'(o_err),   32'(e));
    endtask

    // One start-to-end run; act counts non-paused RUN cycles, so the vector is act/dwell.
    task automatic run(input int dwell, input int errmax, input int pause_at, input int plen,
                       input int abort_at, input int start_at);
        int act = 0;
        int pc = 0;
        int v;
        bit aborted = 1'b0;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        while (act < int'(NV) * dwell) begin
            v = act / dwell;
            chk("run_idx",   32'(o_idx),   32'(v));
            chk("run_a",     32'(o_a),     32'(v >> W));
            chk("run_b",     32'(o_b),     32'(v % (1 << W)));
            chk("run_valid", 32'(o_valid), 1);
            chk("run_busy",  32'(o_busy),  1);
            chk("run_done",  32'(o_done),  0);
            chk("run_err",   32'(o_err),   32'(exp_err(v, errmax)));
            if (act == abort_at) begin
                abort_r = 1'b1;
                tick();
                abort_r = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (act == pause_at && pc < plen) begin
                pause_r = 1'b1;
                pc++;
            end else begin
                pause_r = 1'b0;
            end
            if (act == start_at) start_r = 1'b1;
            tick();
            start_r = 1'b0;
            if (!pause_r) act++;
        end
        pause_r = 1'b0;
        if (aborted) begin
            chk_idle("abort", exp_err(abort_at / dwell, errmax));
        end else begin
            chk("end_done",  32'(o_done),  1);
            chk("end_busy",  32'(o_busy),  0);
            chk("end_valid", 32'(o_valid), 0);
            chk("end_idx",   32'(o_idx),   0);
            chk("end_a",     32'(o_a),     0);
            chk("end_b",     32'(o_b),     0);
            chk("end_err",   32'(o_err),   32'(exp_err(NV, errmax)));
        end
    endtask

    initial begin
        ncmp = 0; nfail = 0;
        sel = 0; mode = 0; inj = '0;
        start_r = 1'b0; pause_r = 1'b0; abort_r = 1'b0;
        rst_n = 1'b0;
        #12;
        chk_idle("rst0", 0);
        sel = 1; #1;
        chk_idle("rst1", 0);
        sel = 0; #1;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // start together with abort in IDLE stays in IDLE
        start_r = 1'b1; abort_r = 1'b1;
        tick();
        start_r = 1'b0; abort_r = 1'b0;
        chk_idle("st_ab", 0);
        tick();
        chk_idle("st_ab2", 0);

        mode = 0;
        run(10, 255, -1, 0, -1, -1);
        abort_r = 1'b1; tick(); abort_r = 1'b0;
        chk_idle("ab_done", 0);

        mode = 1;
        run(10, 255, -1, 0, -1, -1);

        mode = 2; inj = 16'h8000;
        run(10, 255, -1, 0, -1, -1);

        // pause on the last hold cycle of vector 3, which carries a fault
        inj = 16'h0008;
        run(10, 255, 39, 5, -1, -1);

        inj = NV'($urandom);
        run(10, 255, int'($urandom_range(0, 159)), int'($urandom_range(1, 8)), -1, -1);

        inj = NV'($urandom) | 16'h00ff;
        run(10, 255, -1, 0, 70 + int'($urandom_range(0, 9)), -1);
        inj = NV'($urandom);
        run(10, 255, -1, 0, -1, 50);

        sel = 1; #1;
        inj = '1;
        run(1, 3, -1, 0, -1, 5);
        inj = NV'($urandom);
        run(1, 3, int'($urandom_range(0, 15)), 3, -1, -1);

        // asynchronous reset in the middle of a run
        sel = 0; mode = 1; #1;
        start_r = 1'b1; tick(); start_r = 1'b0;
        repeat (65) tick();
        chk("pre_rst_err", 32'(o_err), 32'(exp_err(6, 255)));
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst", 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_idle("post_rst", 0);
        tick();
        chk_idle("post_rst2", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
